// File: rtl/f_fetch.sv
// Fetch stage: issues instruction-memory requests at pc and loads the D-stage registers.
// A word that arrives while D is stalled is parked in a one-entry buffer (HOLD) until D accepts it.
module f_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] new_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc4,
  output logic        d_valid,
  output logic        d_adel
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc4_q, d_pc4_d;
  logic        d_valid_q, d_valid_d;
  logic        d_adel_q, d_adel_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_adel_q, buf_adel_d;

  logic        misaligned;
  logic        word_avail;
  logic [31:0] word_data;
  logic [31:0] pc_plus4;

  assign pc_plus4   = pc_q + 32'd4;
  assign misaligned = (pc_q[1:0] != 2'b00);
  // A misaligned pc never goes to memory; it yields a zero word flagged as an address error.
  assign imem_req   = (state_q == S_FETCH) && !misaligned;
  assign word_avail = (state_q == S_FETCH) && (misaligned || imem_ack);
  assign word_data  = misaligned ? 32'h0000_0000 : imem_rdata;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    d_instr_d   = d_instr_q;
    d_pc_d      = d_pc_q;
    d_pc4_d     = d_pc4_q;
    d_valid_d   = d_valid_q;
    d_adel_d    = d_adel_q;
    buf_instr_d = buf_instr_q;
    buf_adel_d  = buf_adel_q;

    case (state_q)
      S_FETCH: begin
        if (word_avail) begin
          if (!stall) begin
            d_instr_d = word_data;
            d_pc_d    = pc_q;
            d_pc4_d   = pc_plus4;
            d_adel_d  = misaligned;
            d_valid_d = 1'b1;
            pc_d      = new_pc;
          end else begin
            buf_instr_d = word_data;
            buf_adel_d  = misaligned;
            state_d     = S_HOLD;
          end
        end else if (!stall) begin
          d_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          d_instr_d = buf_instr_q;
          d_adel_d  = buf_adel_q;
          d_pc_d    = pc_q;
          d_pc4_d   = pc_plus4;
          d_valid_d = 1'b1;
          pc_d      = new_pc;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      d_instr_q   <= 32'h0;
      d_pc_q      <= 32'h0;
      d_pc4_q     <= 32'h0;
      d_valid_q   <= 1'b0;
      d_adel_q    <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_pc4_q     <= d_pc4_d;
      d_valid_q   <= d_valid_d;
      d_adel_q    <= d_adel_d;
      buf_instr_q <= buf_instr_d;
      buf_adel_q  <= buf_adel_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc4       = pc_plus4;
  assign d_instr   = d_instr_q;
  assign d_pc      = d_pc_q;
  assign d_pc4     = d_pc4_q;
  assign d_valid   = d_valid_q;
  assign d_adel    = d_adel_q;

endmodule

// File: tb/tb_f_fetch.sv
// Random-stimulus bench for f_fetch: a pc-level model predicts the instruction stream,
// a scoreboard queue holds expected D-stage contents, and a downstream monitor consumes them.
module tb_f_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] new_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, pc4, d_instr, d_pc, d_pc4;
  logic        d_valid, d_adel;

  always #5 clk = ~clk;

  f_fetch dut (
    .clk(clk), .reset(reset), .new_pc(new_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .pc4(pc4), .d_instr(d_instr), .d_pc(d_pc), .d_pc4(d_pc4),
    .d_valid(d_valid), .d_adel(d_adel)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        adel;
  } rec_t;

  rec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Downstream consumer: D content is taken on every cycle with d_valid=1 and stall=0.
  always @(negedge clk) begin
    if (mon_en && !reset && d_valid && !stall) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got d_pc=%08h expected no instruction", d_pc);
      end else begin
        rec_t e;
        e = sb.pop_front();
        $display("consume d_pc=%08h d_instr=%08h d_adel=%0d", d_pc, d_instr, d_adel);
        chk("d_pc", d_pc, e.pc);
        chk("d_pc4", d_pc4, e.pc4);
        chk("d_instr", d_instr, e.instr);
        chk("d_adel", {31'h0, d_adel}, {31'h0, e.adel});
      end
    end
  end

  initial begin
    logic [31:0] model_pc, tmp;
    bit          parked, aligned, exp_req, avail, xfer;
    int          wait_cnt, lat, r;

    reset = 1'b1; stall = 1'b1; imem_ack = 1'b1;
    imem_rdata = $urandom; new_pc = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
    chk("rst_d_adel", {31'h0, d_adel}, 32'h0);
    chk("rst_d_instr", d_instr, 32'h0);
    chk("rst_d_pc", d_pc, 32'h0);
    chk("rst_d_pc4", d_pc4, 32'h0);

    reset = 1'b0;
    model_pc = 32'h0000_3000;
    parked = 1'b0; wait_cnt = 0; lat = $urandom_range(0, 2);
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 500; cyc++) begin
      aligned = (model_pc[1:0] == 2'b00);
      exp_req = !parked && aligned;
      chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, model_pc);
      chk("pc4", pc4, model_pc + 32'd4);

      stall = ($urandom_range(0, 99) < 30);
      if (exp_req) begin
        if (wait_cnt >= lat) begin
          imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
          wait_cnt = 0; lat = $urandom_range(0, 2);
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; wait_cnt++;
        end
      end else begin
        // Stray acks with junk data must be ignored while no request is outstanding.
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      end

      avail = parked || (exp_req && imem_ack) || !aligned;
      xfer  = avail && !stall;
      if (xfer) begin
        rec_t e;
        e.pc = model_pc; e.pc4 = model_pc + 32'd4;
        e.instr = aligned ? mem_word(model_pc) : 32'h0;
        e.adel = !aligned;
        sb.push_back(e);
        r = $urandom_range(0, 15); tmp = $urandom;
        if (r < 10)       new_pc = model_pc + 32'd4;
        else if (r == 10) new_pc = {16'h0, tmp[15:2], 2'b10};
        else if (r == 11) new_pc = 32'hFFFF_FFFC;
        else              new_pc = {16'h0, tmp[15:2], 2'b00};
        model_pc = new_pc;
        parked = 1'b0;
      end else begin
        new_pc = $urandom;
        if (avail) parked = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    mon_en = 1'b0;
    chk("sb_drain", {31'h0, (sb.size() <= 1)}, 32'h1);
    sb.delete();

    // Park a word, then reset over it: it must never reach D.
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; new_pc = $urandom;
    @(posedge clk); #1;
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_pc", pc, 32'h0000_3000);
    chk("rst_hold_d_valid", {31'h0, d_valid}, 32'h0);
    chk("rst_hold_req", {31'h0, imem_req}, 32'h1);
    reset = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr); new_pc = 32'h0000_3004;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      $display("zero-wait d_pc=%08h d_instr=%08h d_valid=%0d", d_pc, d_instr, d_valid);
      chk("zw_d_pc", d_pc, 32'h0000_3000 + 32'(4 * k));
      chk("zw_d_valid", {31'h0, d_valid}, 32'h1);
      chk("zw_d_instr", d_instr, mem_word(32'h0000_3000 + 32'(4 * k)));
      imem_rdata = mem_word(imem_addr);
      new_pc = 32'h0000_3000 + 32'(4 * (k + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
